// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter driving the FIFO write port
// Grants one requester at a time for up to MAX_BURST beats, throttled by FIFO fullness.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                        wr_clk,
  input  logic                        clear,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          accept,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_din,
  input  logic                        fifo_full,
  input  logic                        fifo_almost_full,
  input  logic                        fifo_wr_err,
  output logic [ERR_CNT_W-1:0]        wr_err_cnt,
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_owner_q, last_owner_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_W-1:0]     din_q, din_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic                  stall;
  logic                  beat;
  logic                  found;
  logic [IDX_W:0]        cand;
  logic [DATA_W-1:0]     owner_data;

  always_comb begin
    // Almost-full only stalls when a write is already on its way into the last slot.
    stall  = fifo_full | (fifo_almost_full & wr_en_q);
    accept = gnt_q & req & {NUM_REQ{~stall}};
    beat   = |accept;

    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) owner_data = req_data[i*DATA_W +: DATA_W];
    end

    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    wr_en_d      = 1'b0;
    din_d        = din_q;
    found        = 1'b0;
    cand         = '0;
    err_cnt_d    = (fifo_wr_err && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;

    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = {1'b0, last_owner_q} + (IDX_W + 1)'(k);
          if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
          if (!found && req[cand[IDX_W-1:0]]) begin
            found   = 1'b1;
            owner_d = cand[IDX_W-1:0];
          end
        end
        if (found) begin
          gnt_d      = NUM_REQ'(1) << owner_d;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          wr_en_d    = 1'b1;
          din_d      = owner_data;
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if ((beat && beat_cnt_q == LAST_BEAT) || !req[owner_q]) begin
          gnt_d        = '0;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge clear) begin
    if (clear) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      din_q        <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign wr_err_cnt = err_cnt_q;
  assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench for fifo_wr_arbiter
// Requester queues feed the DUT; a transaction-level model predicts every output.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int EW = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          wr_clk = 1'b0;
  logic          clear;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt, accept;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          fifo_full, fifo_almost_full, fifo_wr_err;
  logic [EW-1:0] wr_err_cnt;
  logic          busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .ERR_CNT_W(EW)) dut (
    .wr_clk(wr_clk), .clear(clear), .req(req), .req_data(req_data), .gnt(gnt),
    .accept(accept), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full), .fifo_wr_err(fifo_wr_err),
    .wr_err_cnt(wr_err_cnt), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  typedef logic [DW-1:0] dq_t[$];
  dq_t q[N];

  int n_chk = 0;
  int n_fail = 0;
  logic [N-1:0] en;
  bit drv_full, drv_af, drv_err;

  int m_owner, m_beats, m_last, m_err;
  bit m_wr_en;
  logic [DW-1:0] m_din;

  int wcyc[$];
  logic [DW-1:0] wdat[$];
  int gorder[$];
  int bursts[$];
  int cur_burst, cyc;
  logic [N-1:0] prev_gnt;

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_last = N - 1; m_err = 0; m_wr_en = 0; m_din = '0;
  endtask

  function automatic logic [N-1:0] model_accept();
    logic [N-1:0] a = '0;
    if (m_owner >= 0 && req[m_owner] && !(fifo_full || (fifo_almost_full && m_wr_en)))
      a[m_owner] = 1'b1;
    return a;
  endfunction

  task automatic model_step();
    logic [N-1:0] a = model_accept();
    if (fifo_wr_err) m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
    if (m_owner < 0) begin
      m_wr_en = 0;
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c; m_beats = 0;
          break;
        end
      end
    end else if (a != 0) begin
      m_wr_en = 1;
      m_din = q[m_owner][0];
      void'(q[m_owner].pop_front());
      m_beats++;
      if (m_beats == MB) begin m_last = m_owner; m_owner = -1; end
    end else begin
      m_wr_en = 0;
      if (!req[m_owner]) begin m_last = m_owner; m_owner = -1; end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = en[i] && (q[i].size() > 0);
      req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : DW'($urandom);
    end
    fifo_full = drv_full; fifo_almost_full = drv_af; fifo_wr_err = drv_err;
  endtask

  task automatic cycle();
    logic [N-1:0] ea, eg;
    drive();
    #1;
    ea = model_accept();
    n_chk++;
    if (accept !== ea) begin n_fail++; $display("FAIL accept cyc=%0d got=%b exp=%b", cyc, accept, ea); end
    if (accept != 0) cur_burst++;
    model_step();
    @(posedge wr_clk);
    @(negedge wr_clk);
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    n_chk++;
    if (gnt !== eg) begin n_fail++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
    n_chk++;
    if (fifo_wr_en !== m_wr_en) begin n_fail++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, m_wr_en); end
    n_chk++;
    if (fifo_din !== m_din) begin n_fail++; $display("FAIL din cyc=%0d got=%h exp=%h", cyc, fifo_din, m_din); end
    n_chk++;
    if (wr_err_cnt !== EW'(m_err)) begin n_fail++; $display("FAIL err_cnt cyc=%0d got=%0d exp=%0d", cyc, wr_err_cnt, m_err); end
    n_chk++;
    if (busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_owner >= 0); end
    if (fifo_wr_en) begin wcyc.push_back(cyc); wdat.push_back(fifo_din); end
    if (prev_gnt == 0 && gnt != 0)
      for (int i = 0; i < N; i++) if (gnt[i]) gorder.push_back(i);
    if (prev_gnt != 0 && gnt == 0) begin bursts.push_back(cur_burst); cur_burst = 0; end
    prev_gnt = gnt;
    cyc++;
  endtask

  task automatic clear_logs();
    wcyc.delete(); wdat.delete(); gorder.delete(); bursts.delete();
    cur_burst = 0; cyc = 0; prev_gnt = '0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    en = '0; drv_full = 0; drv_af = 0; drv_err = 0;
    drive();
    clear = 1'b1;
    @(posedge wr_clk);
    @(negedge wr_clk);
    clear = 1'b0;
    model_reset();
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
    n_chk++; if (fifo_din !== '0) begin n_fail++; $display("FAIL reset_din got=%h exp=0", fifo_din); end
    n_chk++; if (wr_err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", wr_err_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (accept !== '0) begin n_fail++; $display("FAIL reset_accept got=%b exp=0", accept); end
    @(negedge wr_clk);
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 5; k++) q[0].push_back(DW'(8'h10 + k));
    en = 4'b0001;
    repeat (12) cycle();
    n_chk++;
    if (wdat.size() != 5) begin n_fail++; $display("FAIL single_count got=%0d exp=5", wdat.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (wdat[k] !== DW'(8'h10 + k)) begin n_fail++; $display("FAIL single_data[%0d] got=%h exp=%h", k, wdat[k], 8'h10 + k); end
      end
      n_chk++;
      if (wcyc[0] != 1 || wcyc[3] != 4 || wcyc[4] != 6)
        begin n_fail++; $display("FAIL single_timing got=%0d,%0d,%0d exp=1,4,6", wcyc[0], wcyc[3], wcyc[4]); end
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 5; k++) q[i].push_back(DW'(i * 16 + k));
    en = 4'b1111;
    repeat (40) cycle();
    n_chk++;
    if (gorder.size() < 5 || bursts.size() < 4 || wdat.size() != 20)
      begin n_fail++; $display("FAIL rr_sizes got=%0d/%0d/%0d exp>=5/>=4/20", gorder.size(), bursts.size(), wdat.size()); end
    else begin
      for (int g = 0; g < 5; g++) begin
        n_chk++;
        if (gorder[g] != exp_order[g]) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", g, gorder[g], exp_order[g]); end
      end
      for (int g = 0; g < 4; g++) begin
        n_chk++;
        if (bursts[g] != MB) begin n_fail++; $display("FAIL rr_burst[%0d] got=%0d exp=%0d", g, bursts[g], MB); end
      end
      for (int b = 0; b < 16; b++) begin
        n_chk++;
        if (wdat[b] !== DW'((b / 4) * 16 + b % 4)) begin n_fail++; $display("FAIL rr_data[%0d] got=%h exp=%h", b, wdat[b], (b / 4) * 16 + b % 4); end
      end
    end
  endtask

  task automatic test_throttle();
    do_reset();
    for (int k = 0; k < 6; k++) q[1].push_back(DW'(8'hA0 + k));
    en = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      drv_af   = (c < 6) ? 1'b1 : (c < 40) ? ($urandom % 3 == 0) : 1'b0;
      drv_full = (c >= 6 && c < 30) ? ($urandom % 4 == 0) : 1'b0;
      cycle();
    end
    n_chk++;
    if (bursts.size() < 2 || bursts[0] != 4 || bursts[1] != 2)
      begin n_fail++; $display("FAIL throttle_bursts got=%0d entries exp=4,2", bursts.size()); end
    n_chk++;
    if (wdat.size() != 6) begin n_fail++; $display("FAIL throttle_count got=%0d exp=6", wdat.size()); end
    else for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (wdat[k] !== DW'(8'hA0 + k)) begin n_fail++; $display("FAIL throttle_data[%0d] got=%h exp=%h", k, wdat[k], 8'hA0 + k); end
    end
  endtask

  task automatic test_early_release();
    int exp_order[3] = '{2, 3, 0};
    do_reset();
    q[0] = '{8'h01, 8'h02};
    q[2] = '{8'h21, 8'h22};
    q[3] = '{8'h31, 8'h32, 8'h33};
    en = 4'b1100;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) en = 4'b1101;
      cycle();
    end
    n_chk++;
    if (bursts.size() < 1 || bursts[0] != 2) begin n_fail++; $display("FAIL early_burst got=%0d entries exp first=2", bursts.size()); end
    n_chk++;
    if (gorder.size() < 3) begin n_fail++; $display("FAIL early_order_size got=%0d exp>=3", gorder.size()); end
    else for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (gorder[g] != exp_order[g]) begin n_fail++; $display("FAIL early_order[%0d] got=%0d exp=%0d", g, gorder[g], exp_order[g]); end
    end
  endtask

  task automatic test_error_counter();
    do_reset();
    drv_err = 1;
    repeat (300) cycle();
    n_chk++; if (wr_err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_sat got=%0d exp=255", wr_err_cnt); end
    repeat (5) cycle();
    drv_err = 0;
    cycle();
    n_chk++; if (wr_err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_hold got=%0d exp=255", wr_err_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    int c = 0;
    do_reset();
    for (int k = 0; k < 6; k++) q[1].push_back(DW'(8'hB0 + k));
    en = 4'b0010;
    drv_err = 1;
    while ((m_owner != 1 || m_beats != 1) && c < 10) begin cycle(); c++; end
    n_chk++;
    if (c == 10) begin n_fail++; $display("FAIL midrst_timeout got=%0d cycles exp<10", c); end
    drive();
    #2 clear = 1'b1;
    #1;
    n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=0", gnt); end
    n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en got=%b exp=0", fifo_wr_en); end
    n_chk++; if (wr_err_cnt !== '0) begin n_fail++; $display("FAIL midrst_err_cnt got=%0d exp=0", wr_err_cnt); end
    @(posedge wr_clk);
    @(negedge wr_clk);
    clear = 1'b0;
    model_reset();
    clear_logs();
    q[0] = '{8'h0A, 8'h0B};
    en = 4'b0011;
    drv_err = 0;
    repeat (20) cycle();
    n_chk++;
    if (gorder.size() < 2 || gorder[0] != 0) begin n_fail++; $display("FAIL midrst_first_owner got=%0d entries exp first=0", gorder.size()); end
    n_chk++;
    if (wdat.size() < 3 || wdat[2] !== 8'hB1) begin n_fail++; $display("FAIL midrst_replay got=%0d writes exp third=b1", wdat.size()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom % 4 == 0 && q[i].size() < 8) q[i].push_back(DW'($urandom));
      if (c % 8 == 0) en = N'($urandom);
      drv_full = ($urandom % 8 == 0);
      drv_af   = ($urandom % 4 == 0);
      drv_err  = ($urandom % 16 == 0);
      cycle();
    end
  endtask

  initial begin
    clear = 1'b1;
    en = '0; drv_full = 0; drv_af = 0; drv_err = 0;
    drive();
    @(negedge wr_clk);
    test_reset();
    test_single();
    test_round_robin();
    test_throttle();
    test_early_release();
    test_error_counter();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter for the asynchronous FIFO. It shares the FIFO write port among NUM_REQ requesters and grants each one a bounded burst. It throttles on full/almost_full and counts write errors reported by the FIFO. It sits entirely in the write clock domain, between the requester agents and the FIFO wr_en/din pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, FIFO data width
MAX_BURST, 4, maximum beats per grant (1..16)
ERR_CNT_W, 8, width of the saturating write-error counter

Ports:
wr_clk  input  1  write-domain clock; all logic on rising edge
clear  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester write request (level, data valid)
req_data  input  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  registered one-hot grant (owner); all-zero when no owner
accept  output  NUM_REQ  combinational; beat from requester i taken this cycle
fifo_wr_en  output  1  registered FIFO write enable
fifo_din  output  DATA_W  registered FIFO write data
fifo_full  input  1  FIFO full
fifo_almost_full  input  1  FIFO has at most one free slot
fifo_wr_err  input  1  FIFO reports write while full
wr_err_cnt  output  ERR_CNT_W  saturating count of fifo_wr_err cycles
busy  output  1  state != IDLE

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, gnt=0, fifo_wr_en=0, fifo_din=0, wr_err_cnt=0, beat_cnt=0, last_owner=NUM_REQ-1, so requester 0 has first priority. Reset mid-burst drops the in-flight beat; no write is issued.
- States: IDLE, BURST.
- IDLE: if |req, select the first i with req[i]=1, scanning last_owner+1, last_owner+2, ... modulo NUM_REQ. Next cycle: gnt=onehot(i), beat_cnt=0, state=BURST. If no req, remain in IDLE. No beat is accepted in IDLE.
- stall = fifo_full | (fifo_almost_full & fifo_wr_en). The second term reserves the slot for the write already registered toward the FIFO.
- BURST: accept[i] = gnt[i] & req[i] & ~stall.
- On an accepted beat: fifo_wr_en<=1 and fifo_din<=req_data[owner] on the next edge (1-cycle latency). Otherwise fifo_wr_en<=0 and fifo_din holds its value.
- beat_cnt increments only on an accepted beat. A stall freezes both the count and the grant.
- Release when the owner's req=0, or when an accepted beat makes beat_cnt reach MAX_BURST. On release: gnt<=0, last_owner<=owner, state<=IDLE. This leaves exactly one idle bubble cycle before the next grant.
- A requester may not drop req while it is stalled and expect its data to be taken. Data is consumed only in accept cycles.
- wr_err_cnt increments by 1 on each cycle with fifo_wr_err=1 and saturates at all-ones (no wrap).
- gnt is always one-hot or zero, and accept is a subset of gnt. At most one FIFO write is issued per cycle.
- Simultaneous release and new requests: the new owner is chosen in the following IDLE cycle using the updated last_owner.

Test Plan:
- Single requester: req[0]=1 with data 0x10,0x11,0x12,0x13,0x14 held continuously, FIFO empty -> gnt[0] rises 1 cycle after req. fifo_wr_en pulses with 0x10..0x13 on 4 consecutive cycles. gnt drops for one bubble cycle, then gnt[0] is re-granted and 0x14 is written.
- Round-robin: req=4'b1111 held, each requester streaming -> grant order 0,1,2,3,0. Each grant gives 4 beats, with 1 bubble between grants.
- Throttle: fifo_almost_full=1 while fifo_wr_en=1 -> accept=0 and beat_cnt frozen. When fifo_full=0 and fifo_almost_full=0 the burst resumes, and the total across the burst is still exactly 4 beats with no lost data.
- Early release: req[2] drops after 2 accepted beats -> gnt returns to 0 and last_owner=2. The next grant goes to requester 3 if it is requesting, before requester 0.
- Error counter: with ERR_CNT_W=8, drive fifo_wr_err=1 for 300 cycles -> wr_err_cnt=255 and stays at 255.
- Reset mid-burst: assert clear between edges during beat 2 -> gnt, fifo_wr_en and wr_err_cnt go to 0 immediately. After release, requester 0 wins first.
